operand_select_stage: RTL and testbench
=======================================

OPERAND_SELECT_STAGE -- requirements
Module: operand_select_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand datapath width.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount field width.
REQ-003 SHALL have parameter IMM_W, default 16, immediate field width used by upper-immediate mode.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 nRST  input  1  reset, asynchronous, active-low.
REQ-006 readReg2  input  WIDTH  register-file operand.
REQ-007 extendedImmediate  input  WIDTH  sign/zero-extended immediate.
REQ-008 shiftAmount  input  SHAMT_W  instruction shift field.
REQ-009 exMemResult  input  WIDTH  forwarded EX/MEM result.
REQ-010 memWbResult  input  WIDTH  forwarded MEM/WB result.
REQ-011 aluSource  input  3  source select, encoding per REQ-016.
REQ-012 inValid  input  1  upstream instruction valid.
REQ-013 stall  input  1  hold this stage.
REQ-014 flush  input  1  kill this stage's contents.
REQ-015 operand  output  WIDTH  registered ALU operand B; operandValid  output  1  registered valid; holding  output  1  high while hold FSM is in HELD.

Function
REQ-016 Select codes: 0 readReg2; 1 extendedImmediate; 2 shiftAmount zero-extended to WIDTH; 3 exMemResult; 4 memWbResult; 5 extendedImmediate[IMM_W-1:0] shifted left by IMM_W, low bits zero (truncated to WIDTH); 6-7 readReg2.
REQ-017 Operand latency one cycle: select value with inValid sampled at edge N appears on operand/operandValid after edge N.
REQ-018 Priority per edge: flush > stall > load.
REQ-019 flush: operand <= 0, operandValid <= 0, hold FSM -> LIVE, hold register <= 0, regardless of stall.
REQ-020 stall without flush: operand and operandValid unchanged.
REQ-021 Load (no stall, no flush): operand <= effective value, operandValid <= inValid.
REQ-022 Effective value: hold register when FSM is HELD and aluSource is 3 or 4, else REQ-016 select value.
REQ-023 Hold FSM states LIVE (reset) and HELD.
REQ-024 LIVE -> HELD on edge with stall=1, flush=0, inValid=1, aluSource in {3,4}; hold register captures select value at that edge.
REQ-025 HELD stays HELD while stall=1 and flush=0; hold register does not change.
REQ-026 HELD -> LIVE on first edge with stall=0 (effective value = hold register at that edge) or on flush.
REQ-027 Non-forward sources (0,1,2,5,6,7) never enter HELD; value taken live at load edge.
REQ-028 holding SHALL equal (state == HELD), registered, no combinational path from inputs.
REQ-029 Stall asserted with inValid=0 SHALL not enter HELD.

Reset
REQ-030 nRST low: operand = 0, operandValid = 0, holding = 0, hold register = 0, FSM = LIVE, immediately without clock.
REQ-031 Reset release mid-stall SHALL start in LIVE; capture occurs only on a subsequent qualifying edge.

Structure
REQ-032 Select encodings SHALL be an enum aluSrc_t (SRC_REG, SRC_IMM, SRC_SHAMT, SRC_FWD_EXMEM, SRC_FWD_MEMWB, SRC_LUI) and FSM states an enum holdState_t, both in the shared cpu_types_pkg.
REQ-033 Combinational selection SHALL be one sub-module operand_mux (parametrised WIDTH/SHAMT_W/IMM_W); FSM, hold register and stage register live in operand_select_stage.

Verification
REQ-034 aluSource=2, shiftAmount=5'h1F, inValid=1, no stall -> next cycle operand=32'h0000001F, operandValid=1.
REQ-035 aluSource=5, extendedImmediate=32'h0000ABCD -> operand=32'hABCD0000.
REQ-036 aluSource=3, exMemResult=32'h11111111, stall=1 for 3 cycles while exMemResult changes to 32'h22222222 -> holding=1 for 3 cycles, operand after release = 32'h11111111, holding=0.
REQ-037 stall=1 and flush=1 same edge while HELD -> operand=0, operandValid=0, holding=0.
REQ-038 nRST asserted mid-HELD between edges -> outputs 0 immediately; after release with aluSource=0, readReg2=32'hDEADBEEF -> operand=32'hDEADBEEF one cycle later.
REQ-039 WIDTH=16 instance, aluSource=5, IMM_W=8, extendedImmediate=16'h00F3 -> operand=16'hF300.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU operand-B source encodings and hold FSM states.
// Imported by the operand select stage and its mux.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    SRC_REG       = 3'd0,
    SRC_IMM       = 3'd1,
    SRC_SHAMT     = 3'd2,
    SRC_FWD_EXMEM = 3'd3,
    SRC_FWD_MEMWB = 3'd4,
    SRC_LUI       = 3'd5
  } aluSrc_t;

  typedef enum logic {
    LIVE = 1'b0,
    HELD = 1'b1
  } holdState_t;

  function automatic logic is_fwd(input logic [2:0] src);
    return (aluSrc_t'(src) == SRC_FWD_EXMEM) ||
           (aluSrc_t'(src) == SRC_FWD_MEMWB);
  endfunction

endpackage

// File: rtl/operand_select_stage_operand_mux.sv
// Combinational ALU operand-B source select.
// Codes 6 and 7 fall back to the register operand.
module operand_mux
  import cpu_types_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int IMM_W   = 16
) (
  input  logic [WIDTH-1:0]   readReg2,
  input  logic [WIDTH-1:0]   extendedImmediate,
  input  logic [SHAMT_W-1:0] shiftAmount,
  input  logic [WIDTH-1:0]   exMemResult,
  input  logic [WIDTH-1:0]   memWbResult,
  input  logic [2:0]         aluSource,
  output logic [WIDTH-1:0]   sel
);

  logic [IMM_W-1:0] imm_lo;
  logic [WIDTH-1:0] lui;

  assign imm_lo = extendedImmediate[IMM_W-1:0];
  assign lui    = WIDTH'(imm_lo) << IMM_W;

  always_comb begin
    sel = readReg2;
    case (aluSrc_t'(aluSource))
      SRC_REG:       sel = readReg2;
      SRC_IMM:       sel = extendedImmediate;
      SRC_SHAMT:     sel = WIDTH'(shiftAmount);
      SRC_FWD_EXMEM: sel = exMemResult;
      SRC_FWD_MEMWB: sel = memWbResult;
      SRC_LUI:       sel = lui;
      default:       sel = readReg2;
    endcase
  end

endmodule

// File: rtl/operand_select_stage.sv
// Operand-B select stage: registers the selected operand and freezes a
// forwarded value across a stall, since the forwarding source moves on.
module operand_select_stage
  import cpu_types_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int IMM_W   = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [WIDTH-1:0]   readReg2,
  input  logic [WIDTH-1:0]   extendedImmediate,
  input  logic [SHAMT_W-1:0] shiftAmount,
  input  logic [WIDTH-1:0]   exMemResult,
  input  logic [WIDTH-1:0]   memWbResult,
  input  logic [2:0]         aluSource,
  input  logic               inValid,
  input  logic               stall,
  input  logic               flush,
  output logic [WIDTH-1:0]   operand,
  output logic               operandValid,
  output logic               holding
);

  holdState_t       state_q;
  holdState_t       state_d;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] eff;
  logic             fwd;
  logic             capture;

  operand_mux #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W),
    .IMM_W  (IMM_W)
  ) u_mux (
    .readReg2         (readReg2),
    .extendedImmediate(extendedImmediate),
    .shiftAmount      (shiftAmount),
    .exMemResult      (exMemResult),
    .memWbResult      (memWbResult),
    .aluSource        (aluSource),
    .sel              (sel)
  );

  assign fwd     = is_fwd(aluSource);
  assign capture = (state_q == LIVE) && (state_d == HELD);
  assign eff     = (state_q == HELD && fwd) ? hold_q : sel;
  assign holding = (state_q == HELD);

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = LIVE;
    end else if (stall) begin
      if (state_q == LIVE && inValid && fwd)
        state_d = HELD;
    end else begin
      state_d = LIVE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= LIVE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hold_q <= '0;
    end else if (flush) begin
      hold_q <= '0;
    end else if (capture) begin
      hold_q <= sel;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      operand      <= '0;
      operandValid <= 1'b0;
    end else if (flush) begin
      operand      <= '0;
      operandValid <= 1'b0;
    end else if (!stall) begin
      operand      <= eff;
      operandValid <= inValid;
    end
  end

endmodule

// File: tb/tb_operand_select_stage.sv
// Directed bench for operand_select_stage: a vector table of single-cycle
// loads plus hand sequences for hold, flush, reset and a 16-bit instance.
module tb_operand_select_stage;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] readReg2 = '0;
  logic [31:0] extendedImmediate = '0;
  logic [4:0]  shiftAmount = '0;
  logic [31:0] exMemResult = '0;
  logic [31:0] memWbResult = '0;
  logic [2:0]  aluSource = '0;
  logic        inValid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] operand;
  logic        operandValid;
  logic        holding;

  logic [15:0] rr2_16 = '0;
  logic [15:0] imm_16 = '0;
  logic [3:0]  sh_16 = '0;
  logic [15:0] exm_16 = '0;
  logic [15:0] mwb_16 = '0;
  logic [2:0]  src_16 = '0;
  logic        inv_16 = 1'b0;
  logic [15:0] op_16;
  logic        v_16;
  logic        h_16;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  operand_select_stage u_dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .readReg2         (readReg2),
    .extendedImmediate(extendedImmediate),
    .shiftAmount      (shiftAmount),
    .exMemResult      (exMemResult),
    .memWbResult      (memWbResult),
    .aluSource        (aluSource),
    .inValid          (inValid),
    .stall            (stall),
    .flush            (flush),
    .operand          (operand),
    .operandValid     (operandValid),
    .holding          (holding)
  );

  operand_select_stage #(
    .WIDTH  (16),
    .SHAMT_W(4),
    .IMM_W  (8)
  ) u_dut16 (
    .CLK              (CLK),
    .nRST             (nRST),
    .readReg2         (rr2_16),
    .extendedImmediate(imm_16),
    .shiftAmount      (sh_16),
    .exMemResult      (exm_16),
    .memWbResult      (mwb_16),
    .aluSource        (src_16),
    .inValid          (inv_16),
    .stall            (1'b0),
    .flush            (1'b0),
    .operand          (op_16),
    .operandValid     (v_16),
    .holding          (h_16)
  );

  typedef struct {
    logic [2:0]  src;
    logic [31:0] rr2;
    logic [31:0] imm;
    logic [4:0]  sh;
    logic [31:0] exm;
    logic [31:0] mwb;
    logic        inv;
    logic [31:0] exp_op;
    logic        exp_v;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [2:0] src, input logic [31:0] rr2,
                       input logic [31:0] exm, input logic inv,
                       input logic st, input logic fl);
    aluSource   = src;
    readReg2    = rr2;
    exMemResult = exm;
    inValid     = inv;
    stall       = st;
    flush       = fl;
  endtask

  initial begin
    vecs[0] = '{3'd0, 32'hA5A5A5A5, 32'h0, 5'h00, 32'h0, 32'h0, 1'b1,
                32'hA5A5A5A5, 1'b1};
    vecs[1] = '{3'd1, 32'h1, 32'hFFFF8000, 5'h03, 32'h2, 32'h3, 1'b1,
                32'hFFFF8000, 1'b1};
    vecs[2] = '{3'd2, 32'h1, 32'h2, 5'h1F, 32'h3, 32'h4, 1'b1,
                32'h0000001F, 1'b1};
    vecs[3] = '{3'd3, 32'h1, 32'h2, 5'h04, 32'h11112222, 32'h4, 1'b1,
                32'h11112222, 1'b1};
    vecs[4] = '{3'd4, 32'h1, 32'h2, 5'h04, 32'h5, 32'h33334444, 1'b1,
                32'h33334444, 1'b1};
    vecs[5] = '{3'd5, 32'h1, 32'h0000ABCD, 5'h04, 32'h5, 32'h6, 1'b1,
                32'hABCD0000, 1'b1};
    vecs[6] = '{3'd6, 32'hCAFE0006, 32'h2, 5'h04, 32'h5, 32'h6, 1'b1,
                32'hCAFE0006, 1'b1};
    vecs[7] = '{3'd7, 32'hCAFE0007, 32'h2, 5'h04, 32'h5, 32'h6, 1'b1,
                32'hCAFE0007, 1'b1};
    vecs[8] = '{3'd0, 32'h0BADF00D, 32'h2, 5'h04, 32'h5, 32'h6, 1'b0,
                32'h0BADF00D, 1'b0};
    vecs[9] = '{3'd5, 32'h1, 32'h1234FFFF, 5'h04, 32'h5, 32'h6, 1'b1,
                32'hFFFF0000, 1'b1};

    #2;
    chk("reset_operand", operand, 32'h0);
    chk("reset_valid", {31'b0, operandValid}, 32'h0);
    chk("reset_holding", {31'b0, holding}, 32'h0);
    #10 nRST = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      aluSource         = vecs[i].src;
      readReg2          = vecs[i].rr2;
      extendedImmediate = vecs[i].imm;
      shiftAmount       = vecs[i].sh;
      exMemResult       = vecs[i].exm;
      memWbResult       = vecs[i].mwb;
      inValid           = vecs[i].inv;
      stall             = 1'b0;
      flush             = 1'b0;
      step();
      chk($sformatf("vec%0d_operand", i), operand, vecs[i].exp_op);
      chk($sformatf("vec%0d_valid", i), {31'b0, operandValid},
          {31'b0, vecs[i].exp_v});
      chk($sformatf("vec%0d_holding", i), {31'b0, holding}, 32'h0);
    end

    // forwarded value frozen across a three-cycle stall
    drive(3'd0, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    chk("pre_hold_operand", operand, 32'h5);
    drive(3'd3, 32'h5, 32'h11111111, 1'b1, 1'b1, 1'b0);
    step();
    exMemResult = 32'h22222222;
    chk("hold1_holding", {31'b0, holding}, 32'h1);
    chk("hold1_operand", operand, 32'h5);
    step();
    chk("hold2_holding", {31'b0, holding}, 32'h1);
    step();
    chk("hold3_holding", {31'b0, holding}, 32'h1);
    chk("hold3_operand", operand, 32'h5);
    stall = 1'b0;
    step();
    chk("release_operand", operand, 32'h11111111);
    chk("release_valid", {31'b0, operandValid}, 32'h1);
    chk("release_holding", {31'b0, holding}, 32'h0);
    step();
    chk("post_release_live", operand, 32'h22222222);

    // stall without a valid forward must not hold
    drive(3'd3, 32'h0, 32'h77777777, 1'b0, 1'b1, 1'b0);
    step();
    chk("stall_invalid_holding", {31'b0, holding}, 32'h0);
    chk("stall_invalid_operand", operand, 32'h22222222);
    drive(3'd1, 32'h0, 32'h77777777, 1'b1, 1'b1, 1'b0);
    step();
    chk("stall_nonfwd_holding", {31'b0, holding}, 32'h0);

    // flush wins over stall while held
    drive(3'd4, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    memWbResult = 32'h44440000;
    step();
    chk("flush_pre_holding", {31'b0, holding}, 32'h1);
    memWbResult = 32'h55550000;
    flush = 1'b1;
    step();
    chk("flush_operand", operand, 32'h0);
    chk("flush_valid", {31'b0, operandValid}, 32'h0);
    chk("flush_holding", {31'b0, holding}, 32'h0);
    stall = 1'b0;
    flush = 1'b0;
    step();
    chk("after_flush_live", operand, 32'h55550000);

    // asynchronous reset while held
    drive(3'd3, 32'h0, 32'h66666666, 1'b1, 1'b1, 1'b0);
    step();
    chk("rst_pre_holding", {31'b0, holding}, 32'h1);
    #3 nRST = 1'b0;
    #1;
    chk("rst_async_operand", operand, 32'h0);
    chk("rst_async_valid", {31'b0, operandValid}, 32'h0);
    chk("rst_async_holding", {31'b0, holding}, 32'h0);
    #2 nRST = 1'b1;
    #1;
    chk("rst_release_holding", {31'b0, holding}, 32'h0);
    drive(3'd0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    chk("rst_deadbeef", operand, 32'hDEADBEEF);
    chk("rst_deadbeef_valid", {31'b0, operandValid}, 32'h1);

    // narrow instance upper-immediate
    src_16 = 3'd5;
    imm_16 = 16'h00F3;
    inv_16 = 1'b1;
    step();
    chk("w16_lui", {16'h0, op_16}, 32'h0000F300);
    chk("w16_valid", {31'b0, v_16}, 32'h1);
    src_16 = 3'd2;
    sh_16  = 4'hF;
    step();
    chk("w16_shamt", {16'h0, op_16}, 32'h0000000F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
